// File: rtl/param_fifo.sv
// ---------------------------------------------------------------------------
// param_fifo : single-clock synchronous FIFO with programmable thresholds
// and sticky overflow/underflow flags.
//
// Build option: define FIFO_FWFT_EN for first-word-fall-through read data.
// Without it, buf_out is a registered output that is loaded on an accepted
// read and holds otherwise.
//
// AFULL_TH must lie in 1..DEPTH and AEMPTY_TH in 0..DEPTH-1.
// ---------------------------------------------------------------------------
module param_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int AFULL_TH  = 56,
    parameter int AEMPTY_TH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              err_clr,
    output logic [DATA_W-1:0] buf_out,
    output logic              buf_empty,
    output logic              buf_full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   fifo_counter,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Thresholds expressed at counter width so every compare is same-width.
    localparam logic [ADDR_W:0] FULL_CNT   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_CNT  = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_CNT = (ADDR_W + 1)'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // Status flags are pure decodes of the registered count, so they move
    // exactly one cycle after the operation that changed the count.
    assign buf_empty    = (fifo_counter == '0);
    assign buf_full     = (fifo_counter == FULL_CNT);
    assign almost_full  = (fifo_counter >= AFULL_CNT);
    assign almost_empty = (fifo_counter <= AEMPTY_CNT);

    // A write into a full FIFO is still taken when a read frees the slot in
    // the same cycle; a read from an empty FIFO is never taken.
    assign wr_ok = wr_en && (!buf_full || rd_en);
    assign rd_ok = rd_en && !buf_empty;

    // Storage array: written on accepted writes, never cleared.
    // NOTE: the memory has no reset branch on purpose; stale words are
    // unreachable because the pointers and count are reset, and leaving the
    // reset off lets synthesis map the array onto RAM.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= buf_in;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the pre-edge value regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_counter <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   fifo_counter <= fifo_counter + 1'b1;
                2'b01:   fifo_counter <= fifo_counter - 1'b1;
                default: fifo_counter <= fifo_counter;
            endcase
        end
    end

    // Sticky error flags; a fresh error in the clearing cycle takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && buf_full && !rd_en) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end

            if (rd_en && buf_empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented combinationally; forced to zero while empty so
    // never-written memory contents cannot leak out.
    assign buf_out = buf_empty ? '0 : mem[rd_ptr];
`else
    // Registered read port: head word captured on an accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_out <= '0;
        end else if (rd_ok) begin
            buf_out <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_param_fifo.sv
// ---------------------------------------------------------------------------
// tb_param_fifo : self-checking bench for param_fifo.
// A queue-based reference model tracks contents, read data and sticky flags;
// every cycle all outputs are compared against it, plus directed checks on
// the specific values named for the basic scenarios.
// ---------------------------------------------------------------------------
module tb_param_fifo;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 6;
    localparam int DEPTH     = 64;
    localparam int AFULL_TH  = 56;
    localparam int AEMPTY_TH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] buf_in;
    logic              wr_en;
    logic              rd_en;
    logic              err_clr;
    logic [DATA_W-1:0] buf_out;
    logic              buf_empty;
    logic              buf_full;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   fifo_counter;
    logic              overflow;
    logic              underflow;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] exp_out;
    logic              exp_ovf;
    logic              exp_udf;

    param_fifo #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .AFULL_TH (AFULL_TH),
        .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .buf_in      (buf_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .err_clr     (err_clr),
        .buf_out     (buf_out),
        .buf_empty   (buf_empty),
        .buf_full    (buf_full),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .fifo_counter(fifo_counter),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic check_all(input string tag);
        int          cnt;
        logic [31:0] want_out;
        cnt = q.size();
`ifdef FIFO_FWFT_EN
        want_out = (cnt == 0) ? 32'd0 : 32'(q[0]);
`else
        want_out = 32'(exp_out);
`endif
        check({tag, ":count"},  32'(fifo_counter), 32'(cnt));
        check({tag, ":empty"},  32'(buf_empty),    32'(cnt == 0));
        check({tag, ":full"},   32'(buf_full),     32'(cnt == DEPTH));
        check({tag, ":afull"},  32'(almost_full),  32'(cnt >= AFULL_TH));
        check({tag, ":aempty"}, 32'(almost_empty), 32'(cnt <= AEMPTY_TH));
        check({tag, ":ovf"},    32'(overflow),     32'(exp_ovf));
        check({tag, ":udf"},    32'(underflow),    32'(exp_udf));
        check({tag, ":out"},    32'(buf_out),      want_out);
    endtask

    // Model of one clock edge, written from the FIFO rules rather than
    // from the hardware structure.
    task automatic model_edge(input logic w, input logic r, input logic [DATA_W-1:0] d,
                              input logic c);
        bit full;
        bit empty;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        if (w && full && !r)  exp_ovf = 1'b1;
        else if (c)           exp_ovf = 1'b0;
        if (r && empty)       exp_udf = 1'b1;
        else if (c)           exp_udf = 1'b0;
        if (r && !empty)      exp_out = q.pop_front();
        if (w && (!full || r)) q.push_back(d);
    endtask

    task automatic step(input string tag, input logic w, input logic r,
                        input logic [DATA_W-1:0] d, input logic c);
        rst     = 1'b0;
        wr_en   = w;
        rd_en   = r;
        buf_in  = d;
        err_clr = c;
        @(posedge clk);
        model_edge(w, r, d, c);
        #1 check_all(tag);
    endtask

    // Reset with all request inputs asserted to prove reset dominates.
    task automatic do_reset(input string tag);
        rst     = 1'b1;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        err_clr = 1'b0;
        buf_in  = 8'($urandom);
        @(posedge clk);
        q.delete();
        exp_out = '0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        #1 check_all(tag);
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin : stim
        logic [DATA_W-1:0] first_word;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; buf_in = '0;
        exp_out = '0; exp_ovf = 1'b0; exp_udf = 1'b0;

        do_reset("rst0");

        // Three writes then one read
        step("w18", 1, 0, 8'd18, 0);
        step("w9",  1, 0, 8'd9,  0);
        step("w20", 1, 0, 8'd20, 0);
        check("basic:count3", 32'(fifo_counter), 32'd3);
        step("rd1", 0, 1, 8'd0, 0);
        check("basic:count2", 32'(fifo_counter), 32'd2);
`ifndef FIFO_FWFT_EN
        check("basic:out18", 32'(buf_out), 32'd18);
`endif

        // Fill to full, then one extra write to trip overflow
        do_reset("rst1");
        first_word = 8'($urandom);
        step("fill0", 1, 0, first_word, 0);
        for (int i = 1; i < DEPTH; i++) step("fill", 1, 0, 8'($urandom), 0);
        check("full:flag", 32'(buf_full), 32'd1);
        check("full:count64", 32'(fifo_counter), 32'd64);
        step("w65", 1, 0, 8'hA5, 0);
        check("ovf:set", 32'(overflow), 32'd1);
        check("ovf:count64", 32'(fifo_counter), 32'd64);
        step("rd_first", 0, 1, 8'd0, 0);
`ifndef FIFO_FWFT_EN
        check("ovf:first_word", 32'(buf_out), 32'(first_word));
`endif
        step("clr_ovf", 0, 0, 8'd0, 1);

        // Threshold edges: fill to 56, drain to 8
        do_reset("rst2");
        for (int i = 0; i < AFULL_TH; i++) step("af_fill", 1, 0, 8'($urandom), 0);
        check("afull:rise", 32'(almost_full), 32'd1);
        for (int i = AFULL_TH; i > AEMPTY_TH; i--) step("ae_drain", 0, 1, 8'd0, 0);
        check("aempty:rise", 32'(almost_empty), 32'd1);

        // Simultaneous read/write on empty
        do_reset("rst3");
        step("rw_empty", 1, 1, 8'd40, 0);
        check("udf:set", 32'(underflow), 32'd1);
        check("udf:count1", 32'(fifo_counter), 32'd1);
        step("udf_clr", 0, 0, 8'd0, 1);
        check("udf:clr", 32'(underflow), 32'd0);
        // Set beats clear in the same cycle
        do_reset("rst3b");
        step("udf_vs_clr", 0, 1, 8'd0, 1);

        // Full FIFO, read+write for 70 cycles across pointer wrap
        do_reset("rst4");
        for (int i = 0; i < DEPTH; i++) step("wrap_fill", 1, 0, 8'($urandom), 0);
        for (int i = 0; i < 70; i++) step("wrap_rw", 1, 1, 8'($urandom), 0);
        check("wrap:no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) step("wrap_drain", 0, 1, 8'd0, 0);

        // Write to empty, observe head; then reset mid-fill
        do_reset("rst5");
        step("w64", 1, 0, 8'd64, 0);
        step("idle", 0, 0, 8'd0, 0);
        for (int i = 0; i < 10; i++) step("midfill", 1, 0, 8'($urandom), 0);
        do_reset("rst_mid");

        // Randomized phases with alternating write/read bias
        for (int seg = 0; seg < 8; seg++) begin
            int pw;
            int pr;
            pw = (seg % 2 == 0) ? 80 : 25;
            pr = (seg % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(199, 0) == 0) begin
                    do_reset("rand_rst");
                end else begin
                    step("rand",
                         $urandom_range(99, 0) < pw,
                         $urandom_range(99, 0) < pr,
                         8'($urandom),
                         $urandom_range(99, 0) < 5);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
